// File: rtl/rs_age_multi.sv
`default_nettype none
// ============================================================================
// Module      : rs_age_multi
// Description : Age-ordered reservation station with multi-port CDB wakeup.
//               Holds up to DEPTH dispatched instructions and issues the
//               single oldest one whose operands are ready and whose
//               functional unit is free.
// Ports       : clk, reset (async, active-low)
//               disp_*   : one allocation per cycle, gated by rs_full
//               cdb_*    : NUM_CDB tag broadcast ports for operand wakeup
//               *_free   : functional-unit availability (mult / ex / mem)
//               flush    : squash every entry
//               rs_full, rs_count : registered occupancy
//               issue_*  : combinational payload of the selected entry
// Options     : RS_CDB_BYPASS_EN - CDB matches of the current cycle count as
//               ready for selection in that same cycle.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef ALU_MULQ
`define ALU_MULQ 5'h0b
`endif
`ifndef NOOP_INST
`define NOOP_INST 32'h47ff041f
`endif

module rs_age_multi #(
    parameter int DEPTH   = 8,
    parameter int PRF_IDX = 6,
    parameter int ROB_IDX = 5,
    parameter int NUM_CDB = 2,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       disp_valid,
    input  logic [PRF_IDX-1:0]         disp_prega_idx,
    input  logic [PRF_IDX-1:0]         disp_pregb_idx,
    input  logic [PRF_IDX-1:0]         disp_pdest_idx,
    input  logic                       disp_prega_valid,
    input  logic                       disp_pregb_valid,
    input  logic [4:0]                 disp_ALUop,
    input  logic                       disp_rd_mem,
    input  logic                       disp_wr_mem,
    input  logic [31:0]                disp_IR,
    input  logic [63:0]                disp_npc,
    input  logic [ROB_IDX-1:0]         disp_rob_idx,
    input  logic [NUM_CDB-1:0]         cdb_valid,
    input  logic [NUM_CDB*PRF_IDX-1:0] cdb_tag,
    input  logic                       mult_free,
    input  logic                       ex_free,
    input  logic                       mem_free,
    input  logic                       flush,
    output logic                       rs_full,
    output logic [CNT_W-1:0]           rs_count,
    output logic                       issue_valid,
    output logic [PRF_IDX-1:0]         issue_pdest_idx,
    output logic [PRF_IDX-1:0]         issue_prega_idx,
    output logic [PRF_IDX-1:0]         issue_pregb_idx,
    output logic [4:0]                 issue_ALUop,
    output logic                       issue_rd_mem,
    output logic                       issue_wr_mem,
    output logic [31:0]                issue_IR,
    output logic [63:0]                issue_npc,
    output logic [ROB_IDX-1:0]         issue_rob_idx
);

    localparam int                 c_AGE_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]   c_DEPTH    = CNT_W'(DEPTH);
    localparam logic [c_AGE_W-1:0] c_RANK_ONE = c_AGE_W'(1);

    // Per-entry state
    logic [DEPTH-1:0]   r_busy;
    logic [DEPTH-1:0]   r_a_rdy;
    logic [DEPTH-1:0]   r_b_rdy;
    logic [c_AGE_W-1:0] r_rank  [DEPTH];
    logic [PRF_IDX-1:0] r_prega [DEPTH];
    logic [PRF_IDX-1:0] r_pregb [DEPTH];
    logic [PRF_IDX-1:0] r_pdest [DEPTH];
    logic [4:0]         r_aluop [DEPTH];
    logic [DEPTH-1:0]   r_rd_mem;
    logic [DEPTH-1:0]   r_wr_mem;
    logic [31:0]        r_ir    [DEPTH];
    logic [63:0]        r_npc   [DEPTH];
    logic [ROB_IDX-1:0] r_rob   [DEPTH];
    logic [CNT_W-1:0]   r_count;
    logic               r_full;

    logic [DEPTH-1:0]   w_cdb_a_hit;
    logic [DEPTH-1:0]   w_cdb_b_hit;
    logic               w_disp_a_rdy;
    logic               w_disp_b_rdy;
    logic [DEPTH-1:0]   w_a_ok;
    logic [DEPTH-1:0]   w_b_ok;
    logic [DEPTH-1:0]   w_fu_free;
    logic [DEPTH-1:0]   w_elig;
    logic               w_found;
    logic [c_AGE_W-1:0] w_sel_rank;
    logic [DEPTH-1:0]   w_sel_oh;
    logic               w_issue;
    logic               w_free_found;
    logic [DEPTH-1:0]   w_free_oh;
    logic               w_alloc;
    logic [DEPTH-1:0]   w_alloc_oh;
    logic [CNT_W-1:0]   w_count_after_issue;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [c_AGE_W-1:0] w_new_rank;

    // CDB tag compare against resident entries and the incoming dispatch
    always_comb begin
        w_cdb_a_hit  = '0;
        w_cdb_b_hit  = '0;
        w_disp_a_rdy = disp_prega_valid;
        w_disp_b_rdy = disp_pregb_valid;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (cdb_valid[k]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (cdb_tag[k*PRF_IDX +: PRF_IDX] == r_prega[i]) w_cdb_a_hit[i] = 1'b1;
                    if (cdb_tag[k*PRF_IDX +: PRF_IDX] == r_pregb[i]) w_cdb_b_hit[i] = 1'b1;
                end
                if (cdb_tag[k*PRF_IDX +: PRF_IDX] == disp_prega_idx) w_disp_a_rdy = 1'b1;
                if (cdb_tag[k*PRF_IDX +: PRF_IDX] == disp_pregb_idx) w_disp_b_rdy = 1'b1;
            end
        end
    end

`ifdef RS_CDB_BYPASS_EN
    assign w_a_ok = r_a_rdy | w_cdb_a_hit;
    assign w_b_ok = r_b_rdy | w_cdb_b_hit;
`else
    // Registered readiness only keeps the tag compare off the select path
    assign w_a_ok = r_a_rdy;
    assign w_b_ok = r_b_rdy;
`endif

    // Eligibility and oldest-first selection; busy ranks are unique
    always_comb begin
        w_fu_free  = '0;
        w_elig     = '0;
        w_found    = 1'b0;
        w_sel_rank = '0;
        w_sel_oh   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_rd_mem[i] || r_wr_mem[i])   w_fu_free[i] = mem_free;
            else if (r_aluop[i] == `ALU_MULQ) w_fu_free[i] = mult_free;
            else                              w_fu_free[i] = ex_free;
            w_elig[i] = r_busy[i] & w_a_ok[i] & w_b_ok[i] & w_fu_free[i];
            if (w_elig[i] && (!w_found || (r_rank[i] < w_sel_rank))) begin
                w_found     = 1'b1;
                w_sel_rank  = r_rank[i];
                w_sel_oh    = '0;
                w_sel_oh[i] = 1'b1;
            end
        end
    end

    assign w_issue = w_found & ~flush;

    // Lowest free slot in registered state; a slot freed by this cycle's
    // issue is still busy here and so is not reused until next cycle
    always_comb begin
        w_free_found = 1'b0;
        w_free_oh    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!r_busy[i] && !w_free_found) begin
                w_free_found = 1'b1;
                w_free_oh[i] = 1'b1;
            end
        end
    end

    assign w_alloc             = disp_valid & ~r_full & ~flush & w_free_found;
    assign w_alloc_oh          = w_free_oh & {DEPTH{w_alloc}};
    assign w_count_after_issue = r_count - CNT_W'(w_issue);
    assign w_count_nxt         = w_count_after_issue + CNT_W'(w_alloc);
    // Never full when allocating, so the post-issue count fits a rank
    assign w_new_rank          = w_count_after_issue[c_AGE_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy  <= '0;
            r_a_rdy <= '0;
            r_b_rdy <= '0;
            for (int i = 0; i < DEPTH; i++) r_rank[i] <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else if (flush) begin
            r_busy  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                if (w_cdb_a_hit[i]) r_a_rdy[i] <= 1'b1;
                if (w_cdb_b_hit[i]) r_b_rdy[i] <= 1'b1;
                if (w_issue && r_busy[i] && (r_rank[i] > w_sel_rank))
                    r_rank[i] <= r_rank[i] - c_RANK_ONE;
                if (w_issue && w_sel_oh[i]) r_busy[i] <= 1'b0;
                if (w_alloc_oh[i]) begin
                    r_busy[i]  <= 1'b1;
                    r_a_rdy[i] <= w_disp_a_rdy;
                    r_b_rdy[i] <= w_disp_b_rdy;
                    r_rank[i]  <= w_new_rank;
                end
            end
        end
    end

    // Payload is only observed while busy, so it needs no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_alloc_oh[i]) begin
                r_prega[i]  <= disp_prega_idx;
                r_pregb[i]  <= disp_pregb_idx;
                r_pdest[i]  <= disp_pdest_idx;
                r_aluop[i]  <= disp_ALUop;
                r_rd_mem[i] <= disp_rd_mem;
                r_wr_mem[i] <= disp_wr_mem;
                r_ir[i]     <= disp_IR;
                r_npc[i]    <= disp_npc;
                r_rob[i]    <= disp_rob_idx;
            end
        end
    end

    always_comb begin
        issue_pdest_idx = '0;
        issue_prega_idx = '0;
        issue_pregb_idx = '0;
        issue_ALUop     = '0;
        issue_rd_mem    = 1'b0;
        issue_wr_mem    = 1'b0;
        issue_IR        = `NOOP_INST;
        issue_npc       = '0;
        issue_rob_idx   = '0;
        if (w_issue) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_sel_oh[i]) begin
                    issue_pdest_idx = r_pdest[i];
                    issue_prega_idx = r_prega[i];
                    issue_pregb_idx = r_pregb[i];
                    issue_ALUop     = r_aluop[i];
                    issue_rd_mem    = r_rd_mem[i];
                    issue_wr_mem    = r_wr_mem[i];
                    issue_IR        = r_ir[i];
                    issue_npc       = r_npc[i];
                    issue_rob_idx   = r_rob[i];
                end
            end
        end
    end

    assign issue_valid = w_issue;
    assign rs_full     = r_full;
    assign rs_count    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_rs_age_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_age_multi
// Description : Self-checking bench for rs_age_multi. Expected issues are
//               queued when the enabling stimulus is driven and compared
//               against the DUT whenever it reports an issue.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef ALU_MULQ
`define ALU_MULQ 5'h0b
`endif
`ifndef NOOP_INST
`define NOOP_INST 32'h47ff041f
`endif

module tb_rs_age_multi;

    localparam int DEPTH   = 8;
    localparam int PRF_IDX = 6;
    localparam int ROB_IDX = 5;
    localparam int NUM_CDB = 2;
    localparam int CNT_W   = 4;
    localparam logic [4:0] c_ADDQ = 5'h00;
    localparam logic [4:0] c_MULQ = `ALU_MULQ;

    logic                       clk;
    logic                       reset;
    logic                       disp_valid;
    logic [PRF_IDX-1:0]         disp_prega_idx, disp_pregb_idx, disp_pdest_idx;
    logic                       disp_prega_valid, disp_pregb_valid;
    logic [4:0]                 disp_ALUop;
    logic                       disp_rd_mem, disp_wr_mem;
    logic [31:0]                disp_IR;
    logic [63:0]                disp_npc;
    logic [ROB_IDX-1:0]         disp_rob_idx;
    logic [NUM_CDB-1:0]         cdb_valid;
    logic [NUM_CDB*PRF_IDX-1:0] cdb_tag;
    logic                       mult_free, ex_free, mem_free, flush;
    logic                       rs_full;
    logic [CNT_W-1:0]           rs_count;
    logic                       issue_valid;
    logic [PRF_IDX-1:0]         issue_pdest_idx, issue_prega_idx, issue_pregb_idx;
    logic [4:0]                 issue_ALUop;
    logic                       issue_rd_mem, issue_wr_mem;
    logic [31:0]                issue_IR;
    logic [63:0]                issue_npc;
    logic [ROB_IDX-1:0]         issue_rob_idx;

    typedef struct {
        logic [ROB_IDX-1:0] rob;
        logic [PRF_IDX-1:0] pdest;
        logic [31:0]        ir;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    rs_age_multi #(
        .DEPTH(DEPTH), .PRF_IDX(PRF_IDX), .ROB_IDX(ROB_IDX), .NUM_CDB(NUM_CDB), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .disp_valid(disp_valid),
        .disp_prega_idx(disp_prega_idx), .disp_pregb_idx(disp_pregb_idx),
        .disp_pdest_idx(disp_pdest_idx),
        .disp_prega_valid(disp_prega_valid), .disp_pregb_valid(disp_pregb_valid),
        .disp_ALUop(disp_ALUop), .disp_rd_mem(disp_rd_mem), .disp_wr_mem(disp_wr_mem),
        .disp_IR(disp_IR), .disp_npc(disp_npc), .disp_rob_idx(disp_rob_idx),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .mult_free(mult_free), .ex_free(ex_free), .mem_free(mem_free), .flush(flush),
        .rs_full(rs_full), .rs_count(rs_count), .issue_valid(issue_valid),
        .issue_pdest_idx(issue_pdest_idx), .issue_prega_idx(issue_prega_idx),
        .issue_pregb_idx(issue_pregb_idx), .issue_ALUop(issue_ALUop),
        .issue_rd_mem(issue_rd_mem), .issue_wr_mem(issue_wr_mem),
        .issue_IR(issue_IR), .issue_npc(issue_npc), .issue_rob_idx(issue_rob_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Payload is derived from the ROB index so expectations can be rebuilt
    function automatic logic [PRF_IDX-1:0] pdest_of(input logic [ROB_IDX-1:0] rob);
        return PRF_IDX'(rob) + PRF_IDX'(32);
    endfunction

    function automatic logic [31:0] ir_of(input logic [ROB_IDX-1:0] rob);
        return 32'h1000_0000 | 32'(rob);
    endfunction

    task automatic push_exp(input logic [ROB_IDX-1:0] rob);
        exp_t x;
        x.rob   = rob;
        x.pdest = pdest_of(rob);
        x.ir    = ir_of(rob);
        sb.push_back(x);
    endtask

    task automatic idle_inputs();
        disp_valid = 1'b0;
        cdb_valid  = '0;
        cdb_tag    = '0;
        flush      = 1'b0;
    endtask

    task automatic drive_disp(input logic [ROB_IDX-1:0] rob,
                              input logic [PRF_IDX-1:0] pa, input logic pav,
                              input logic [PRF_IDX-1:0] pb, input logic pbv,
                              input logic [4:0] op, input logic rd, input logic wr);
        disp_valid       = 1'b1;
        disp_rob_idx     = rob;
        disp_prega_idx   = pa;
        disp_prega_valid = pav;
        disp_pregb_idx   = pb;
        disp_pregb_valid = pbv;
        disp_pdest_idx   = pdest_of(rob);
        disp_ALUop       = op;
        disp_rd_mem      = rd;
        disp_wr_mem      = wr;
        disp_IR          = ir_of(rob);
        disp_npc         = 64'h4000 + 64'(rob) * 64'd4;
    endtask

    // Scoreboard monitor: samples mid low-phase, after inputs have settled
    always begin
        @(negedge clk);
        #2;
        if (reset === 1'b1 && issue_valid === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_issue: got rob %0d, no issue expected", issue_rob_idx);
            end else begin
                e = sb.pop_front();
                if (issue_rob_idx !== e.rob) begin
                    n_fail++;
                    $display("FAIL issue_rob: got %0d expected %0d", issue_rob_idx, e.rob);
                end
                n_checks++;
                if (issue_pdest_idx !== e.pdest) begin
                    n_fail++;
                    $display("FAIL issue_pdest: got %0d expected %0d", issue_pdest_idx, e.pdest);
                end
                n_checks++;
                if (issue_IR !== e.ir) begin
                    n_fail++;
                    $display("FAIL issue_IR: got %h expected %h", issue_IR, e.ir);
                end
            end
        end
    end

    task automatic test_reset();
        reset     = 1'b0;
        idle_inputs();
        drive_disp(0, 0, 1'b0, 0, 1'b0, c_ADDQ, 1'b0, 1'b0);
        disp_valid = 1'b0;
        mult_free = 1'b1; ex_free = 1'b1; mem_free = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (rs_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", rs_count); end
        n_checks++; if (rs_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", rs_full); end
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_issue_valid: got %b expected 0", issue_valid); end
        n_checks++; if (issue_IR !== `NOOP_INST) begin n_fail++; $display("FAIL reset_issue_IR: got %h expected %h", issue_IR, `NOOP_INST); end
        reset = 1'b1;
    endtask

    task automatic test_fill();
        ex_free = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            drive_disp(ROB_IDX'(j), 6'd1, 1'b1, 6'd2, 1'b1, c_ADDQ, 1'b0, 1'b0);
            push_exp(ROB_IDX'(j));
        end
        @(negedge clk);
        drive_disp(5'd8, 6'd1, 1'b1, 6'd2, 1'b1, c_ADDQ, 1'b0, 1'b0);
        #1;
        n_checks++; if (rs_full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b expected 1", rs_full); end
        n_checks++; if (rs_count !== 4'd8) begin n_fail++; $display("FAIL fill_count: got %0d expected 8", rs_count); end
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL fill_blocked: got %b expected 0", issue_valid); end
        @(negedge clk);
        drive_disp(5'd9, 6'd1, 1'b1, 6'd2, 1'b1, c_ADDQ, 1'b0, 1'b0);
        ex_free = 1'b1;
        #1;
        n_checks++; if (rs_count !== 4'd8) begin n_fail++; $display("FAIL fill_drop9: got %0d expected 8", rs_count); end
        n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL fill_issue: got %b expected 1", issue_valid); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (rs_full !== 1'b0) begin n_fail++; $display("FAIL full_deassert: got %b expected 0", rs_full); end
        n_checks++; if (rs_count !== 4'd7) begin n_fail++; $display("FAIL full_drop_count: got %0d expected 7", rs_count); end
        repeat (7) @(negedge clk);
        #1;
        n_checks++; if (rs_count !== 4'd0) begin n_fail++; $display("FAIL drain_count: got %0d expected 0", rs_count); end
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL drain_issue: got %b expected 0", issue_valid); end
    endtask

    task automatic test_age_wakeup();
        @(negedge clk);
        drive_disp(5'd10, 6'd1, 1'b1, 6'd12, 1'b0, c_ADDQ, 1'b0, 1'b0);
        @(negedge clk);
        drive_disp(5'd11, 6'd3, 1'b1, 6'd4, 1'b1, c_ADDQ, 1'b0, 1'b0);
        push_exp(5'd11);
        #1;
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL age_wait: got %b expected 0", issue_valid); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL age_young_first: got %b expected 1", issue_valid); end
        n_checks++; if (rs_count !== 4'd2) begin n_fail++; $display("FAIL age_count: got %0d expected 2", rs_count); end
        @(negedge clk);
        cdb_valid = 2'b10;
        cdb_tag   = {6'd12, 6'd5};
        push_exp(5'd10);
        #1;
`ifdef RS_CDB_BYPASS_EN
        n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL wake_same_cycle: got %b expected 1", issue_valid); end
`else
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL wake_same_cycle: got %b expected 0", issue_valid); end
`endif
        @(negedge clk);
        idle_inputs();
        #1;
`ifdef RS_CDB_BYPASS_EN
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL wake_next_cycle: got %b expected 0", issue_valid); end
`else
        n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL wake_next_cycle: got %b expected 1", issue_valid); end
`endif
        @(negedge clk);
        #1;
        n_checks++; if (rs_count !== 4'd0) begin n_fail++; $display("FAIL age_drain: got %0d expected 0", rs_count); end
    endtask

    task automatic test_class();
        mult_free = 1'b0; ex_free = 1'b1; mem_free = 1'b0;
        @(negedge clk);
        drive_disp(5'd20, 6'd1, 1'b1, 6'd2, 1'b1, c_MULQ, 1'b0, 1'b0);
        @(negedge clk);
        drive_disp(5'd21, 6'd1, 1'b1, 6'd2, 1'b1, c_ADDQ, 1'b0, 1'b0);
        push_exp(5'd21);
        #1;
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL class_mult_blocked: got %b expected 0", issue_valid); end
        @(negedge clk);
        // memory op carrying a MULQ opcode must still be gated by mem_free
        drive_disp(5'd22, 6'd1, 1'b1, 6'd2, 1'b1, c_MULQ, 1'b1, 1'b0);
        #1;
        n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL class_ex_issue: got %b expected 1", issue_valid); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL class_all_blocked: got %b expected 0", issue_valid); end
        @(negedge clk);
        mult_free = 1'b1;
        push_exp(5'd20);
        #1;
        n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL class_mult_issue: got %b expected 1", issue_valid); end
        @(negedge clk);
        #1;
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL class_mem_blocked: got %b expected 0", issue_valid); end
        @(negedge clk);
        mem_free = 1'b1;
        push_exp(5'd22);
        #1;
        n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL class_mem_issue: got %b expected 1", issue_valid); end
        @(negedge clk);
        #1;
        n_checks++; if (rs_count !== 4'd0) begin n_fail++; $display("FAIL class_drain: got %0d expected 0", rs_count); end
    endtask

    task automatic test_snoop();
        @(negedge clk);
        drive_disp(5'd30, 6'd1, 1'b1, 6'd20, 1'b0, c_ADDQ, 1'b0, 1'b0);
        cdb_valid = 2'b01;
        cdb_tag   = {6'd33, 6'd20};
        push_exp(5'd30);
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL snoop_issue: got %b expected 1", issue_valid); end
        @(negedge clk);
        #1;
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL snoop_after: got %b expected 0", issue_valid); end
    endtask

    task automatic test_flush();
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            drive_disp(ROB_IDX'(24 + j), 6'd1, 1'b1, 6'd40, 1'b0, c_ADDQ, 1'b0, 1'b0);
        end
        @(negedge clk);
        drive_disp(5'd29, 6'd1, 1'b1, 6'd2, 1'b1, c_ADDQ, 1'b0, 1'b0);
        flush     = 1'b1;
        cdb_valid = 2'b01;
        cdb_tag   = {6'd0, 6'd40};
        #1;
        n_checks++; if (rs_count !== 4'd5) begin n_fail++; $display("FAIL flush_pre_count: got %0d expected 5", rs_count); end
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_issue: got %b expected 0", issue_valid); end
        @(negedge clk);
        idle_inputs();
        cdb_valid = 2'b01;
        cdb_tag   = {6'd0, 6'd40};
        #1;
        n_checks++; if (rs_count !== 4'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", rs_count); end
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_after: got %b expected 0", issue_valid); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (rs_count !== 4'd0) begin n_fail++; $display("FAIL flush_disp_dropped: got %0d expected 0", rs_count); end
        n_checks++; if (issue_IR !== `NOOP_INST) begin n_fail++; $display("FAIL flush_noop: got %h expected %h", issue_IR, `NOOP_INST); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive_disp(5'd1, 6'd1, 1'b1, 6'd50, 1'b0, c_ADDQ, 1'b0, 1'b0);
        @(negedge clk);
        drive_disp(5'd2, 6'd1, 1'b1, 6'd50, 1'b0, c_ADDQ, 1'b0, 1'b0);
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (rs_count !== 4'd2) begin n_fail++; $display("FAIL mid_pre_count: got %0d expected 2", rs_count); end
        #1 reset = 1'b0;
        #1;
        n_checks++; if (rs_count !== 4'd0) begin n_fail++; $display("FAIL mid_async_count: got %0d expected 0", rs_count); end
        @(negedge clk);
        reset     = 1'b1;
        cdb_valid = 2'b01;
        cdb_tag   = {6'd0, 6'd50};
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_issue: got %b expected 0", issue_valid); end
        n_checks++; if (rs_count !== 4'd0) begin n_fail++; $display("FAIL mid_count: got %0d expected 0", rs_count); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_age_wakeup();
        test_class();
        test_snoop();
        test_flush();
        test_reset_mid();
        @(negedge clk);
        #3;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expected issues never seen, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rs_age_multi.md
# rs_age_multi

Parametrised reservation station for the out-of-order core. It holds DEPTH dispatched instructions until their operands are ready, and wakes operands from NUM_CDB common-data-bus ports. Each cycle it issues the single oldest ready instruction whose functional unit is free. It sits between dispatch (RAT/ROB allocation) and the FU issue stage, and supports a full squash on branch mispredict.

## Interface
- DEPTH, 8: number of entries; any value ≥2.
- PRF_IDX, 6: physical register tag width.
- ROB_IDX, 5: ROB index width.
- NUM_CDB, 2: number of CDB broadcast ports; any value ≥1.
- CNT_W, $clog2(DEPTH+1): occupancy counter width (derived).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- disp_valid  in  1  allocate one entry this cycle.
- disp_prega_idx / disp_pregb_idx / disp_pdest_idx  in  PRF_IDX each  source A/B tags and destination tag.
- disp_prega_valid / disp_pregb_valid  in  1 each  source value already available in PRF.
- disp_ALUop  in  5; disp_rd_mem, disp_wr_mem  in  1 each; disp_IR  in  32; disp_npc  in  64; disp_rob_idx  in  ROB_IDX  payload.
- cdb_valid  in  NUM_CDB  per-port broadcast valid.
- cdb_tag  in  NUM_CDB*PRF_IDX  port k tag in bits [k*PRF_IDX +: PRF_IDX].
- mult_free, ex_free, mem_free  in  1 each  FU can accept an instruction this cycle.
- flush  in  1  squash all entries.
- rs_full  out  1  all DEPTH entries busy (registered).
- rs_count  out  CNT_W  busy entry count (registered).
- issue_valid  out  1  an instruction is issued this cycle.
- issue_pdest_idx / issue_prega_idx / issue_pregb_idx, issue_ALUop, issue_rd_mem, issue_wr_mem, issue_IR, issue_npc, issue_rob_idx  out  payload of the issued entry.

## Operation
- Per-entry state: busy, a_rdy, b_rdy, age rank (0 = oldest, $clog2(DEPTH) bits), payload.
- Allocate: when disp_valid & !rs_full, write the lowest-index entry that is free in registered state.
  - An entry freed by issue in the same cycle is not reusable until the next cycle.
  - disp_valid while rs_full: dispatch dropped, no state change. Dispatch must gate on rs_full.
- Capture-time snoop: a_rdy = disp_prega_valid | (any cdb_valid[k] with cdb_tag[k] == disp_prega_idx). Same rule for b_rdy.
- Wakeup: a busy entry sets a_rdy (b_rdy) when any valid CDB port tag equals its prega (pregb). Multiple matching ports are harmless.
- FU class per entry:
  - mem if rd_mem | wr_mem;
  - else mult if ALUop == `ALU_MULQ;
  - else ex.
- Eligible = busy & A ready & B ready & the class's *_free signal.
- Select: among eligible entries, the one with the smallest age rank. Ranks among busy entries are unique, so no tie-break is needed.
- Age maintenance at each edge:
  - Busy entries with rank greater than the issued entry's rank decrement.
  - A new entry gets rank = busy count after this cycle's issue removal.
- Issue: issue_valid and payload are combinational from the selected entry. The entry clears busy at the next edge.
- issue_valid = 0: payload outputs are 0, except issue_IR = `NOOP_INST.
- Flush: all busy bits clear at the next edge. That cycle, dispatch is dropped and issue_valid is forced to 0. Flush has priority over everything.
- rs_count next = count + accepted dispatch - issue; flush sets it to 0. rs_full = (rs_count == DEPTH).
- Reset (async, active-low), all entries: busy = 0, a_rdy = 0, b_rdy = 0, rank = 0.
  - rs_count = 0, rs_full = 0, issue_valid = 0, issue payload 0 / NOOP.
  - Reset asserted mid-operation discards all entries immediately.

## Timing
- Dispatch to earliest issue: 1 cycle (operands ready at dispatch).
- CDB wakeup to issue: 0 cycles with RS_CDB_BYPASS_EN, 1 cycle without.
- Single issue per cycle; throughput is 1 instruction/cycle.
- Simultaneous dispatch + issue when full: issue proceeds, dispatch is dropped, and rs_full deasserts next cycle.
- Simultaneous CDB broadcast + dispatch of a matching tag: operand is captured ready. This holds in both configurations.

## Configuration
- RS_CDB_BYPASS_EN defined: an operand matched by a CDB port in the current cycle counts as ready for eligibility in that same cycle, giving same-cycle wakeup-issue.
- RS_CDB_BYPASS_EN undefined: eligibility uses only registered a_rdy/b_rdy. Wakeup-to-issue is 1 cycle, and the CDB compare is off the select path.

## Test plan
- Reset with reset=0, then release: rs_count=0, rs_full=0, issue_valid=0, issue_IR=`NOOP_INST.
- Dispatch 8 entries, all operands valid, ex_free=0 (DEPTH=8) → rs_full=1 after 8th edge. A 9th dispatch is dropped. Set ex_free=1 → the 8 entries issue in dispatch order, 1/cycle, and rs_count falls to 0.
- Age ordering under wakeup:
  - Dispatch A (pregb=12, not valid), then B (both valid).
  - B issues first.
  - cdb_valid=2'b10, cdb_tag port1=12 → A issues the same cycle with bypass, or the next cycle without.
- Class gating: dispatch MULQ then ADDQ, mult_free=0, ex_free=1 → ADDQ issues. Then set mult_free=1 → MULQ issues.
- Dispatch of pregb=20 in the same cycle cdb port0 tag=20 → entry ready; issues next cycle.
- 5 busy entries, flush=1 with disp_valid=1 → issue_valid=0 that cycle, then rs_count=0 and no issue afterwards.
